// File: rtl/pd_debug_chain.sv
// pd_debug_chain: in-line packet-descriptor (PD) debug pipeline with NUM_STAGES stages.
// Each stage registers the PD once. It matches the PD against two masked value fields and keeps
// saturating hit and byte counters. It can capture one PD per arm. A match can also set the
// TRIG_BIT of the forwarded PD, so a stage further down the pipeline captures the same PD.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid, in_pd     PD input (no backpressure, one PD per cycle)
//   cfg_f1_value/mask   per-stage field1 match value/mask, stage s at [s*PD_WIDTH +: PD_WIDTH]
//   cfg_f2_value/mask   per-stage field2 match value/mask
//   cfg_en              per stage 4 bits: [0] f1 en, [1] f2 en, [2] capture en, [3] trigger en
//   cap_clear           per-stage re-arm pulse
//   cnt_clear           clear all counters
//   rd_stage_sel        stage selected for readout
//   rd_word_sel         32-bit word of the captured PD selected for readout
//   out_valid, out_pd   PD output after the last stage
//   cap_pulse           per-stage one-cycle capture strobe
//   cap_valid           per-stage sticky "capture held" flag
//   rd_cap_word         selected captured word (registered)
//   rd_f1_cnt           selected stage field1 hit count (registered)
//   rd_f2_cnt           selected stage field2 hit count (registered)
//   rd_f1_bytes         selected stage field1 byte sum (registered)
module pd_debug_chain #(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned PD_WIDTH        = 128,
    parameter int unsigned TRIG_BIT        = 113,
    parameter int unsigned PKT_SIZE_OFFSET = 0,
    parameter int unsigned PKT_SIZE_WIDTH  = 12,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned BCNT_WIDTH      = 48,
    localparam int unsigned NUM_WORDS      = (PD_WIDTH + 31) / 32,
    localparam int unsigned SSEL_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int unsigned WSEL_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [PD_WIDTH-1:0]              in_pd,
    input  logic [NUM_STAGES*PD_WIDTH-1:0]   cfg_f1_value,
    input  logic [NUM_STAGES*PD_WIDTH-1:0]   cfg_f1_mask,
    input  logic [NUM_STAGES*PD_WIDTH-1:0]   cfg_f2_value,
    input  logic [NUM_STAGES*PD_WIDTH-1:0]   cfg_f2_mask,
    input  logic [NUM_STAGES*4-1:0]          cfg_en,
    input  logic [NUM_STAGES-1:0]            cap_clear,
    input  logic                             cnt_clear,
    input  logic [SSEL_W-1:0]                rd_stage_sel,
    input  logic [WSEL_W-1:0]                rd_word_sel,
    output logic                             out_valid,
    output logic [PD_WIDTH-1:0]              out_pd,
    output logic [NUM_STAGES-1:0]            cap_pulse,
    output logic [NUM_STAGES-1:0]            cap_valid,
    output logic [31:0]                      rd_cap_word,
    output logic [CNT_WIDTH-1:0]             rd_f1_cnt,
    output logic [CNT_WIDTH-1:0]             rd_f2_cnt,
    output logic [BCNT_WIDTH-1:0]            rd_f1_bytes
);

    localparam int unsigned BSUM_W = BCNT_WIDTH + 1;
    localparam int unsigned PAD_W  = NUM_WORDS * 32;

    // Per-stage state gathered into packed arrays for chaining and readout.
    logic [NUM_STAGES-1:0]                 stage_v;
    logic [NUM_STAGES-1:0][PD_WIDTH-1:0]   stage_pd;
    logic [NUM_STAGES-1:0][PAD_W-1:0]      cap_pad;
    logic [NUM_STAGES-1:0][CNT_WIDTH-1:0]  f1_cnt_all;
    logic [NUM_STAGES-1:0][CNT_WIDTH-1:0]  f2_cnt_all;
    logic [NUM_STAGES-1:0][BCNT_WIDTH-1:0] f1_bytes_all;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic [PD_WIDTH-1:0]       f1_val, f1_msk, f2_val, f2_msk;
        logic [3:0]                en;
        logic                      v_in;
        logic [PD_WIDTH-1:0]       pd_in;
        logic [PD_WIDTH-1:0]       fwd_pd;
        logic                      f1_hit, f2_hit, trig_in, cap_evt;
        logic [PKT_SIZE_WIDTH-1:0] pkt_size;
        logic [BSUM_W-1:0]         byte_sum;

        logic                      v_q;
        logic [PD_WIDTH-1:0]       pd_q;
        logic [PD_WIDTH-1:0]       cap_q, cap_d;
        logic                      cap_valid_q, cap_valid_d;
        logic                      cap_pulse_q;
        logic [CNT_WIDTH-1:0]      f1_cnt_q, f1_cnt_d;
        logic [CNT_WIDTH-1:0]      f2_cnt_q, f2_cnt_d;
        logic [BCNT_WIDTH-1:0]     f1_bytes_q, f1_bytes_d;

        assign f1_val = cfg_f1_value[s*PD_WIDTH +: PD_WIDTH];
        assign f1_msk = cfg_f1_mask[s*PD_WIDTH +: PD_WIDTH];
        assign f2_val = cfg_f2_value[s*PD_WIDTH +: PD_WIDTH];
        assign f2_msk = cfg_f2_mask[s*PD_WIDTH +: PD_WIDTH];
        assign en     = cfg_en[s*4 +: 4];

        if (s == 0) begin : g_head
            assign v_in  = in_valid;
            assign pd_in = in_pd;
        end else begin : g_body
            assign v_in  = stage_v[s-1];
            assign pd_in = stage_pd[s-1];
        end

        always_comb begin
            f1_hit   = v_in & en[0] & (((pd_in ^ f1_val) & f1_msk) == '0);
            f2_hit   = v_in & en[1] & (((pd_in ^ f2_val) & f2_msk) == '0);
            trig_in  = v_in & pd_in[TRIG_BIT];
            fwd_pd   = pd_in;
            fwd_pd[TRIG_BIT] = pd_in[TRIG_BIT] | (en[3] & f1_hit);
            // A re-arm in the same cycle as an event counts as armed, so the new PD is taken.
            cap_evt  = en[2] & (~cap_valid_q | cap_clear[s]) & (f1_hit | trig_in);
            pkt_size = pd_in[PKT_SIZE_OFFSET +: PKT_SIZE_WIDTH];
            byte_sum = {1'b0, f1_bytes_q} + BSUM_W'(pkt_size);
        end

        always_comb begin
            cap_d       = cap_q;
            cap_valid_d = cap_valid_q;
            if (cap_evt) begin
                cap_d       = pd_in;
                cap_valid_d = 1'b1;
            end else if (cap_clear[s]) begin
                cap_valid_d = 1'b0;
            end
        end

        // Saturating counters; cnt_clear overrides any increment in the same cycle.
        always_comb begin
            f1_cnt_d   = f1_cnt_q;
            f2_cnt_d   = f2_cnt_q;
            f1_bytes_d = f1_bytes_q;
            if (cnt_clear) begin
                f1_cnt_d   = '0;
                f2_cnt_d   = '0;
                f1_bytes_d = '0;
            end else begin
                if (f1_hit && (f1_cnt_q != '1)) begin
                    f1_cnt_d = f1_cnt_q + CNT_WIDTH'(1);
                end
                if (f2_hit && (f2_cnt_q != '1)) begin
                    f2_cnt_d = f2_cnt_q + CNT_WIDTH'(1);
                end
                if (f1_hit) begin
                    f1_bytes_d = byte_sum[BCNT_WIDTH] ? '1 : byte_sum[BCNT_WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q         <= 1'b0;
                pd_q        <= '0;
                cap_q       <= '0;
                cap_valid_q <= 1'b0;
                cap_pulse_q <= 1'b0;
                f1_cnt_q    <= '0;
                f2_cnt_q    <= '0;
                f1_bytes_q  <= '0;
            end else begin
                v_q         <= v_in;
                pd_q        <= fwd_pd;
                cap_q       <= cap_d;
                cap_valid_q <= cap_valid_d;
                cap_pulse_q <= cap_evt;
                f1_cnt_q    <= f1_cnt_d;
                f2_cnt_q    <= f2_cnt_d;
                f1_bytes_q  <= f1_bytes_d;
            end
        end

        assign stage_v[s]      = v_q;
        assign stage_pd[s]     = pd_q;
        assign cap_pad[s]      = PAD_W'(cap_q);
        assign f1_cnt_all[s]   = f1_cnt_q;
        assign f2_cnt_all[s]   = f2_cnt_q;
        assign f1_bytes_all[s] = f1_bytes_q;
        assign cap_pulse[s]    = cap_pulse_q;
        assign cap_valid[s]    = cap_valid_q;
    end

    assign out_valid = stage_v[NUM_STAGES-1];
    assign out_pd    = stage_pd[NUM_STAGES-1];

    // Readout mux; selectors that match no stage/word leave the zero default.
    logic [31:0]           rd_word_d, rd_word_q;
    logic [CNT_WIDTH-1:0]  rd_f1_d, rd_f1_q, rd_f2_d, rd_f2_q;
    logic [BCNT_WIDTH-1:0] rd_bytes_d, rd_bytes_q;

    always_comb begin
        rd_word_d  = '0;
        rd_f1_d    = '0;
        rd_f2_d    = '0;
        rd_bytes_d = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (rd_stage_sel == SSEL_W'(s)) begin
                rd_f1_d    = f1_cnt_all[s];
                rd_f2_d    = f2_cnt_all[s];
                rd_bytes_d = f1_bytes_all[s];
                for (int w = 0; w < NUM_WORDS; w++) begin
                    if (rd_word_sel == WSEL_W'(w)) begin
                        rd_word_d = cap_pad[s][w*32 +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_q  <= '0;
            rd_f1_q    <= '0;
            rd_f2_q    <= '0;
            rd_bytes_q <= '0;
        end else begin
            rd_word_q  <= rd_word_d;
            rd_f1_q    <= rd_f1_d;
            rd_f2_q    <= rd_f2_d;
            rd_bytes_q <= rd_bytes_d;
        end
    end

    assign rd_cap_word = rd_word_q;
    assign rd_f1_cnt   = rd_f1_q;
    assign rd_f2_cnt   = rd_f2_q;
    assign rd_f1_bytes = rd_bytes_q;

endmodule

// File: tb/tb_pd_debug_chain.sv
// Directed bench for pd_debug_chain: a default build, plus a CNT_WIDTH=2 build on the same
// stimulus for the counter saturation case.
module tb_pd_debug_chain;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_pd;
    logic [383:0] cfg_f1_value, cfg_f1_mask, cfg_f2_value, cfg_f2_mask;
    logic [11:0]  cfg_en;
    logic [2:0]   cap_clear;
    logic         cnt_clear;
    logic [1:0]   rd_stage_sel;
    logic [1:0]   rd_word_sel;

    logic         out_valid;
    logic [127:0] out_pd;
    logic [2:0]   cap_pulse, cap_valid;
    logic [31:0]  rd_cap_word, rd_f1_cnt, rd_f2_cnt;
    logic [47:0]  rd_f1_bytes;

    logic         s_out_valid;
    logic [127:0] s_out_pd;
    logic [2:0]   s_cap_pulse, s_cap_valid;
    logic [31:0]  s_rd_cap_word;
    logic [1:0]   s_rd_f1_cnt, s_rd_f2_cnt;
    logic [47:0]  s_rd_f1_bytes;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pd_debug_chain u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pd(in_pd),
        .cfg_f1_value(cfg_f1_value), .cfg_f1_mask(cfg_f1_mask),
        .cfg_f2_value(cfg_f2_value), .cfg_f2_mask(cfg_f2_mask),
        .cfg_en(cfg_en), .cap_clear(cap_clear), .cnt_clear(cnt_clear),
        .rd_stage_sel(rd_stage_sel), .rd_word_sel(rd_word_sel),
        .out_valid(out_valid), .out_pd(out_pd), .cap_pulse(cap_pulse), .cap_valid(cap_valid),
        .rd_cap_word(rd_cap_word), .rd_f1_cnt(rd_f1_cnt), .rd_f2_cnt(rd_f2_cnt),
        .rd_f1_bytes(rd_f1_bytes)
    );

    pd_debug_chain #(.CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pd(in_pd),
        .cfg_f1_value(cfg_f1_value), .cfg_f1_mask(cfg_f1_mask),
        .cfg_f2_value(cfg_f2_value), .cfg_f2_mask(cfg_f2_mask),
        .cfg_en(cfg_en), .cap_clear(cap_clear), .cnt_clear(cnt_clear),
        .rd_stage_sel(rd_stage_sel), .rd_word_sel(rd_word_sel),
        .out_valid(s_out_valid), .out_pd(s_out_pd), .cap_pulse(s_cap_pulse),
        .cap_valid(s_cap_valid), .rd_cap_word(s_rd_cap_word), .rd_f1_cnt(s_rd_f1_cnt),
        .rd_f2_cnt(s_rd_f2_cnt), .rd_f1_bytes(s_rd_f1_bytes)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_pd(input logic [31:0] w3, input logic [11:0] size);
        return {w3, 32'h5A5A_5A5A, 32'hC3C3_C3C3, 20'h0, size};
    endfunction

    task automatic set_f1(input int s, input logic [127:0] value, input logic [127:0] mask);
        cfg_f1_value[s*128 +: 128] = value;
        cfg_f1_mask[s*128 +: 128]  = mask;
    endtask

    logic [127:0] sent [5];
    logic [31:0]  w3_tab [3];
    logic [11:0]  sz_tab [3];
    int           pulses;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pd = '0;
        cfg_f1_value = '0; cfg_f1_mask = '0; cfg_f2_value = '0; cfg_f2_mask = '0;
        cfg_en = '0; cap_clear = '0; cnt_clear = 1'b0; rd_stage_sel = '0; rd_word_sel = '0;
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_cap_valid", 128'(cap_valid), 128'h0);
        check("rst_rd_f1_cnt", 128'(rd_f1_cnt), 128'h0);
        rst = 1'b0;
        tick();

        // 1: pass-through with everything disabled, exactly three cycles of latency.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                in_valid = 1'b1;
                in_pd    = mk_pd(32'hA000_0000 + 32'(i), 12'(i * 3 + 1));
                sent[i]  = in_pd;
            end else begin
                in_valid = 1'b0;
                in_pd    = '0;
            end
            tick();
            if (i == 1 || i == 7) check("t1_out_valid_idle", 128'(out_valid), 128'h0);
            if (i >= 2 && i <= 6) begin
                check("t1_out_valid", 128'(out_valid), 128'h1);
                check("t1_out_pd", out_pd, sent[i-2]);
            end
            if (cap_pulse != 3'b000) pulses++;
        end
        check("t1_no_pulses", 128'(pulses), 128'h0);
        tick();
        check("t1_f1_cnt", 128'(rd_f1_cnt), 128'h0);
        check("t1_f1_bytes", 128'(rd_f1_bytes), 128'h0);

        // 2: stage0 size match with capture.
        set_f1(0, 128'h040, 128'hFFF);
        cfg_en[3:0] = 4'b0101;
        w3_tab[0] = 32'h1111_1111; w3_tab[1] = 32'h4444_4444; w3_tab[2] = 32'h8888_8888;
        sz_tab[0] = 12'h040;       sz_tab[1] = 12'h040;       sz_tab[2] = 12'h041;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pd    = mk_pd(w3_tab[i], sz_tab[i]);
            tick();
            check("t2_cap_pulse0", 128'(cap_pulse[0]), (i == 0) ? 128'h1 : 128'h0);
        end
        in_valid = 1'b0;
        tick();
        check("t2_cap_valid0", 128'(cap_valid[0]), 128'h1);
        rd_stage_sel = 2'd0; rd_word_sel = 2'd0;
        tick();
        check("t2_f1_cnt", 128'(rd_f1_cnt), 128'h2);
        check("t2_f1_bytes", 128'(rd_f1_bytes), 128'h80);
        check("t2_f2_cnt", 128'(rd_f2_cnt), 128'h0);
        check("t2_cap_word0", 128'(rd_cap_word), 128'h40);
        rd_word_sel = 2'd3;
        tick();
        check("t2_cap_word3", 128'(rd_cap_word), 128'h1111_1111);

        // 3: stage0 match sets the trigger bit, stage2 captures on it.
        set_f1(0, 128'h055, 128'hFFF);
        cfg_en[3:0]  = 4'b1001;
        cfg_en[11:8] = 4'b0100;
        in_valid = 1'b1;
        in_pd    = mk_pd(32'h0, 12'h055);
        tick();
        in_valid = 1'b0;
        check("t3_no_pulse0", 128'(cap_pulse[0]), 128'h0);
        tick();
        check("t3_pulse2_early", 128'(cap_pulse[2]), 128'h0);
        tick();
        check("t3_out_valid", 128'(out_valid), 128'h1);
        check("t3_out_pd_trig", out_pd, mk_pd(32'h0002_0000, 12'h055));
        check("t3_pulse2", 128'(cap_pulse[2]), 128'h1);
        rd_stage_sel = 2'd2; rd_word_sel = 2'd3;
        tick();
        check("t3_cap2_word3", 128'(rd_cap_word), 128'h0002_0000);
        check("t3_cap_valid1", 128'(cap_valid[1]), 128'h0);

        // 4: counter saturation on the CNT_WIDTH=2 build, out-of-range readout.
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pd    = mk_pd(32'h0100_0000 + 32'(i), 12'h055);
            tick();
        end
        in_valid = 1'b0;
        rd_stage_sel = 2'd0;
        tick();
        tick();
        check("t4_f1_cnt", 128'(rd_f1_cnt), 128'h5);
        check("t4_f1_bytes", 128'(rd_f1_bytes), 128'h1A9);
        check("t4_sat_cnt", 128'(s_rd_f1_cnt), 128'h3);
        rd_stage_sel = 2'd3; rd_word_sel = 2'd0;
        tick();
        check("t4_oor_cnt", 128'(rd_f1_cnt), 128'h0);
        check("t4_oor_word", 128'(rd_cap_word), 128'h0);
        tick();
        tick();

        // 5: re-arm and capture in the same cycle; clear and hit in the same cycle.
        cfg_en[3:0] = 4'b0000;
        cfg_en[7:4] = 4'b0101;
        set_f1(1, 128'h0AA, 128'hFFF);
        in_valid = 1'b1;
        in_pd    = mk_pd(32'h0000_A001, 12'h0AA);
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_first_pulse1", 128'(cap_pulse[1]), 128'h1);
        check("t5_first_valid1", 128'(cap_valid[1]), 128'h1);
        in_valid = 1'b1;
        in_pd    = mk_pd(32'h0000_B002, 12'h0AA);
        tick();
        in_valid  = 1'b0;
        cap_clear = 3'b010;
        tick();
        cap_clear = 3'b000;
        check("t5_clr_pulse1", 128'(cap_pulse[1]), 128'h1);
        check("t5_clr_valid1", 128'(cap_valid[1]), 128'h1);
        in_valid = 1'b1;
        in_pd    = mk_pd(32'h0000_C003, 12'h0AA);
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_oneshot_pulse1", 128'(cap_pulse[1]), 128'h0);
        rd_stage_sel = 2'd1; rd_word_sel = 2'd3;
        tick();
        check("t5_cap1_word3", 128'(rd_cap_word), 128'h0000_B002);
        check("t5_f1_cnt1", 128'(rd_f1_cnt), 128'h3);

        cfg_en[3:0] = 4'b0001;
        set_f1(0, 128'h033, 128'hFFF);
        in_valid  = 1'b1;
        in_pd     = mk_pd(32'h0000_D004, 12'h033);
        cnt_clear = 1'b1;
        tick();
        in_valid  = 1'b0;
        cnt_clear = 1'b0;
        rd_stage_sel = 2'd0;
        tick();
        check("t5_clr_wins_cnt", 128'(rd_f1_cnt), 128'h0);
        check("t5_clr_wins_bytes", 128'(rd_f1_bytes), 128'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_after_clr_cnt", 128'(rd_f1_cnt), 128'h1);
        check("t5_after_clr_bytes", 128'(rd_f1_bytes), 128'h33);

        // 6: asynchronous reset with PDs in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pd    = mk_pd(32'h6000_0000 + 32'(i), 12'h033);
            tick();
        end
        in_valid = 1'b0;
        check("t6_pre_out_valid", 128'(out_valid), 128'h1);
        check("t6_pre_f1_cnt", 128'(rd_f1_cnt), 128'h3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 128'(out_valid), 128'h0);
        check("t6_rst_f1_cnt", 128'(rd_f1_cnt), 128'h0);
        check("t6_rst_f1_bytes", 128'(rd_f1_bytes), 128'h0);
        check("t6_rst_cap_valid", 128'(cap_valid), 128'h0);
        check("t6_rst_sat_cnt", 128'(s_rd_f1_cnt), 128'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_idle", 128'(out_valid), 128'h0);
        in_valid = 1'b1;
        in_pd    = mk_pd(32'h7000_0000, 12'h033);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_post_out_valid", 128'(out_valid), 128'h1);
        check("t6_post_out_pd", out_pd, mk_pd(32'h7000_0000, 12'h033));
        tick();
        check("t6_post_f1_cnt", 128'(rd_f1_cnt), 128'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
